// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I instruction fetch unit with a one-entry output buffer
//
// Purpose:
//    Owns the architectural PC. It issues one instruction memory request at a
//    time and buffers the returned word together with its PC for the decode
//    stage. Redirects from execute replace the PC in any state. A request that
//    is still in flight when a redirect arrives is drained, and its response is
//    discarded.
//
// Optional feature (macro IFETCH_MISALIGN_CHECK_EN):
//    If this macro is defined, a redirect whose target has bits [1:0] != 0 sets
//    the sticky fetch_fault output and parks the unit in FAULT until rst.
//    If it is not defined, the target's low two bits are cleared silently and
//    fetch_fault is tied to 0.
//
// Ports:
//    clk              in   1   system clock, rising edge
//    rst              in   1   asynchronous active-high reset
//    imem_req_valid   out  1   fetch request valid (decoded from state)
//    imem_req_ready   in   1   memory accepts the request this cycle
//    imem_req_addr    out  32  word-aligned fetch address (the PC)
//    imem_resp_valid  in   1   response valid, one per accepted request
//    imem_resp_data   in   32  instruction word
//    redirect_valid   in   1   one-cycle pulse: replace the PC
//    redirect_target  in   32  new PC
//    inst_valid       out  1   output buffer holds a valid instruction
//    inst_ready       in   1   decode consumes the instruction this cycle
//    inst             out  32  buffered instruction word
//    inst_pc          out  32  PC of inst
//    fetch_fault      out  1   sticky misaligned-redirect flag
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fetch_fault
);

`ifdef IFETCH_MISALIGN_CHECK_EN
   typedef enum logic [2:0] {S_REQ, S_WAIT, S_OUT, S_DRAIN, S_FAULT} state_t;
`else
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DRAIN} state_t;
`endif

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] inst_n, inst_pc_n;
   logic        inst_valid_n;
   logic        redirect_en;

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        fault, fault_n;

   // Once the unit is faulted, redirects can no longer restart it.
   assign redirect_en = redirect_valid && (state != S_FAULT);
   assign fetch_fault = fault;
`else
   assign redirect_en = redirect_valid;
   assign fetch_fault = 1'b0;
`endif

   assign imem_req_valid = (state == S_REQ);
   assign imem_req_addr  = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
         inst_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         fault      <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         inst       <= inst_n;
         inst_pc    <= inst_pc_n;
         inst_valid <= inst_valid_n;
`ifdef IFETCH_MISALIGN_CHECK_EN
         fault      <= fault_n;
`endif
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      inst_n       = inst;
      inst_pc_n    = inst_pc;
      inst_valid_n = inst_valid;
`ifdef IFETCH_MISALIGN_CHECK_EN
      fault_n      = fault;
`endif

      case (state)
         S_REQ: begin
            if (imem_req_ready) begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               inst_n       = imem_resp_data;
               inst_pc_n    = pc;
               inst_valid_n = 1'b1;
               pc_n         = pc + 32'd4;
               state_n      = S_OUT;
            end
         end
         S_OUT: begin
            if (inst_ready) begin
               inst_valid_n = 1'b0;
               state_n      = S_REQ;
            end
         end
         S_DRAIN: begin
            if (imem_resp_valid) begin
               state_n = S_REQ;
            end
         end
`ifdef IFETCH_MISALIGN_CHECK_EN
         S_FAULT: begin
            state_n = S_FAULT;
         end
`endif
         default: state_n = S_REQ;
      endcase

      // A redirect overrides everything above. The buffer is flushed, and a
      // response that lands in the same cycle never reaches the buffer.
      if (redirect_en) begin
         pc_n         = redirect_target & 32'hFFFF_FFFC;
         inst_n       = inst;
         inst_pc_n    = inst_pc;
         inst_valid_n = 1'b0;
         case (state)
            // If the old address is accepted in this cycle, its response must still be drained.
            S_REQ:           state_n = imem_req_ready ? S_DRAIN : S_REQ;
            S_WAIT, S_DRAIN: state_n = imem_resp_valid ? S_REQ : S_DRAIN;
            S_OUT:           state_n = S_REQ;
            default:         state_n = S_REQ;
         endcase
`ifdef IFETCH_MISALIGN_CHECK_EN
         if (redirect_target[1:0] != 2'b00) begin
            fault_n = 1'b1;
            state_n = S_FAULT;
         end
`endif
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fetch_fault;

   instruction_fetch #(.RESET_PC(RPC)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .fetch_fault     (fetch_fault)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // The memory image: each word holds its own address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a;
   endfunction

   // Instruction memory: one response per accepted request, lat cycles later.
   typedef struct { int due; logic [31:0] addr; } mreq_t;
   mreq_t mq[$];
   int    lat = 1;
   int    cyc = 0;

   always @(negedge clk) begin : memory
      mreq_t r;
      if (rst) begin
         mq.delete();
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
         end
         // The handshake values seen here are the ones sampled at the next edge.
         if (imem_req_valid && imem_req_ready) begin
            r.due  = cyc + lat;
            r.addr = imem_req_addr;
            mq.push_back(r);
         end
      end
   end

   // Program-order model: exp_pc is the PC of the next instruction decode must see.
   typedef struct { logic [31:0] inst; logic [31:0] pc; int cyc; } dlv_t;
   dlv_t        dlv[$];
   logic [31:0] exp_pc = RPC;
   bit          exp_fault = 1'b0;
   bit          hold_prev = 1'b0;
   bit          redir_prev = 1'b0;
   logic [31:0] hold_inst = 32'h0;
   logic [31:0] hold_pc = 32'h0;

   always @(posedge clk) begin : model
      dlv_t d;
      bit   redir;
      bit   mis;
      cyc++;
      if (rst) begin
         exp_pc     = RPC;
         exp_fault  = 1'b0;
         hold_prev  = 1'b0;
         redir_prev = 1'b0;
      end else begin
         redir      = redirect_valid && !exp_fault;
         hold_prev  = inst_valid && !inst_ready && !redir;
         hold_inst  = inst;
         hold_pc    = inst_pc;
         redir_prev = redir;
         if (inst_valid && inst_ready) begin
            d.inst = inst;
            d.pc   = inst_pc;
            d.cyc  = cyc;
            dlv.push_back(d);
            exp_pc = exp_pc + 32'd4;
         end
         if (redir) begin
            mis = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            mis = (redirect_target[1:0] != 2'b00);
`endif
            if (mis) exp_fault = 1'b1;
            else     exp_pc = {redirect_target[31:2], 2'b00};
         end
      end
   end

   // Per-cycle checker
   always @(negedge clk) begin : compare
      if (!rst) begin
         check("fault_flag", {31'h0, fetch_fault}, {31'h0, exp_fault});
         if (exp_fault) begin
            check("fault_no_req", {31'h0, imem_req_valid}, 32'h0);
            check("fault_no_inst", {31'h0, inst_valid}, 32'h0);
         end else begin
            if (imem_req_valid) begin
               check("req_addr", imem_req_addr, exp_pc);
               check("req_vs_buffer", {31'h0, inst_valid}, 32'h0);
            end
            if (inst_valid) begin
               check("inst_pc", inst_pc, exp_pc);
               check("inst_word", inst, mem_word(inst_pc));
            end
            if (hold_prev) begin
               check("hold_valid", {31'h0, inst_valid}, 32'h1);
               check("hold_inst", inst, hold_inst);
               check("hold_pc", inst_pc, hold_pc);
            end
            if (redir_prev) check("flush_after_redirect", {31'h0, inst_valid}, 32'h0);
         end
      end
   end

   task automatic wait_dlv(input int n, input string name);
      for (int i = 0; i < 60 && dlv.size() < n; i++) @(negedge clk);
      checks++;
      if (dlv.size() < n) begin
         errors++;
         $display("FAIL %s: timeout, deliveries=%0d, needed %0d", name, dlv.size(), n);
      end
   endtask

   task automatic wait_inst(input string name);
      for (int i = 0; i < 60 && !inst_valid; i++) @(negedge clk);
      checks++;
      if (!inst_valid) begin
         errors++;
         $display("FAIL %s: timeout waiting for inst_valid, got 0, expected 1", name);
      end
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 60 && !imem_req_valid; i++) @(negedge clk);
      checks++;
      if (!imem_req_valid) begin
         errors++;
         $display("FAIL %s: timeout waiting for imem_req_valid, got 0, expected 1", name);
      end
   endtask

   task automatic check_dlv(input int idx, input logic [31:0] pc, input string name);
      if (idx < 0 || idx >= dlv.size()) begin
         checks++;
         errors++;
         $display("FAIL %s: delivery %0d missing, got %0d deliveries", name, idx, dlv.size());
      end else begin
         check({name, "_pc"}, dlv[idx].pc, pc);
         check({name, "_inst"}, dlv[idx].inst, pc);
      end
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect_valid  = 1'b1;
      redirect_target = target;
      @(negedge clk);
      redirect_valid  = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      repeat (2) @(negedge clk);
      check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_fault", {31'h0, fetch_fault}, 32'h0);
      check("rst_req_addr", imem_req_addr, 32'h0000_0100);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);

      // Fetch the first instructions back to back, then hold the third one.
      wait_dlv(2, "stream");
      inst_ready = 1'b0;
      wait_inst("held_arrive");
      for (int i = 0; i < 5; i++) begin
         check("held_pc", inst_pc, 32'h0000_0108);
         check("held_inst", inst, 32'h0000_0108);
         check("held_no_req", {31'h0, imem_req_valid}, 32'h0);
         @(negedge clk);
      end
      lat = 2;
      inst_ready = 1'b1;
      @(negedge clk);
      check("release_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("release_req_addr", imem_req_addr, 32'h0000_010C);
      check_dlv(0, 32'h0000_0100, "dlv0");
      check_dlv(1, 32'h0000_0104, "dlv1");
      check_dlv(2, 32'h0000_0108, "dlv2");
      if (dlv.size() >= 2) check("throughput", dlv[1].cyc - dlv[0].cyc, 32'd3);

      // Redirect while the request for 0x10C is waiting on a slow response.
      @(negedge clk);
      check("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
      pulse_redirect(32'h0000_0200);
      check("drain_no_req", {31'h0, imem_req_valid}, 32'h0);
      check("drain_no_inst", {31'h0, inst_valid}, 32'h0);
      lat = 1;
      wait_req("req_after_drain");
      check("redirect_wait_addr", imem_req_addr, 32'h0000_0200);
      n = dlv.size();
      wait_dlv(n + 1, "dlv_200");
      check_dlv(dlv.size() - 1, 32'h0000_0200, "redir_wait");

      // Redirect in OUT together with a consume: the redirect wins.
      wait_inst("out_300");
      pulse_redirect(32'h0000_0300);
      check("out_flush", {31'h0, inst_valid}, 32'h0);
      check("out_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("out_req_addr", imem_req_addr, 32'h0000_0300);
      n = dlv.size();
      wait_dlv(n + 1, "dlv_300");
      check_dlv(dlv.size() - 1, 32'h0000_0300, "redir_out");

      // PC wraps modulo 2^32.
      wait_inst("out_wrap");
      pulse_redirect(32'hFFFF_FFFC);
      n = dlv.size();
      wait_dlv(n + 1, "dlv_wrap");
      check_dlv(dlv.size() - 1, 32'hFFFF_FFFC, "wrap");
      wait_req("req_wrap");
      check("wrap_req_addr", imem_req_addr, 32'h0000_0000);

      // Misaligned redirect target.
      wait_inst("out_mis");
      pulse_redirect(32'h0000_0202);
`ifdef IFETCH_MISALIGN_CHECK_EN
      check("mis_fault", {31'h0, fetch_fault}, 32'h1);
      check("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
      pulse_redirect(32'h0000_0400);
      for (int i = 0; i < 5; i++) begin
         check("fault_stuck_req", {31'h0, imem_req_valid}, 32'h0);
         check("fault_stuck_flag", {31'h0, fetch_fault}, 32'h1);
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      check("fault_cleared", {31'h0, fetch_fault}, 32'h0);
      check("fault_rst_inst", {31'h0, inst_valid}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("fault_rst_req", {31'h0, imem_req_valid}, 32'h1);
      check("fault_rst_addr", imem_req_addr, 32'h0000_0100);
`else
      check("mis_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("mis_req_addr", imem_req_addr, 32'h0000_0200);
      check("mis_no_fault", {31'h0, fetch_fault}, 32'h0);
      n = dlv.size();
      wait_dlv(n + 1, "dlv_mis");
      check_dlv(dlv.size() - 1, 32'h0000_0200, "mis");
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
